// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the audio mixer with delta-sigma DAC output.
package audio_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int GAIN_UNITY = 8;   // gain code for 1.0
  localparam int ADR_CTRL   = 15;  // control register address (mute / flag clear)
  localparam int GAIN_SHIFT = 3;   // gain fixed point: 3 fractional bits

endpackage

// File: rtl/dsm_mod.sv
// Delta-sigma bitstream modulator for the mixed sample.
// Build option: define DSM_2ND_ORDER_EN for a second-order error-feedback loop;
// the default build uses a first-order accumulate-and-carry modulator.
module dsm_mod #(
  parameter int MW = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [MW-1:0] din_i,
  output logic          dout_o
);

`ifdef DSM_2ND_ORDER_EN
  // Sign bit plus guard bits so u = x + 2*e1 - e2 never overflows.
  localparam int EW = MW + 4;
  localparam logic signed [EW-1:0] FS   = EW'(1) <<< MW;
  localparam logic signed [EW-1:0] HALF = EW'(1) <<< (MW - 1);

  logic signed [EW-1:0] e1_q, e2_q, u, e_d;
  logic                 q;

  // Quantize the noise-shaped input and form the clamped quantization error.
  always_comb begin
    u   = $signed({4'b0000, din_i}) + (e1_q <<< 1) - e2_q;
    q   = (u >= HALF);
    e_d = q ? (u - FS) : u;
    if (e_d > FS)  e_d = FS;
    if (e_d < -FS) e_d = -FS;
  end

  // Error delay line and output bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e1_q   <= '0;
      e2_q   <= '0;
      dout_o <= 1'b0;
    end else begin
      e1_q   <= e_d;
      e2_q   <= e1_q;
      dout_o <= q;
    end
  end
`else
  logic [MW-1:0] fb_q;
  logic [MW:0]   sum;

  assign sum = {1'b0, din_i} + {1'b0, fb_q};

  // Carry out of the phase accumulator is the output bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fb_q   <= '0;
      dout_o <= 1'b0;
    end else begin
      fb_q   <= sum[MW-1:0];
      dout_o <= sum[MW];
    end
  end
`endif

endmodule

// File: rtl/audio_mixer_dsm.sv
// Multi-channel gain mixer: one multiply-accumulate per cycle, saturating
// output register, sticky clip/overrun flags and a delta-sigma bitstream.
// Build option DSM_2ND_ORDER_EN selects the second-order modulator in dsm_mod.
module audio_mixer_dsm
  import audio_mix_pkg::*;
#(
  parameter  int NCH = 6,
  parameter  int IW  = 10,
  parameter  int GW  = 4,
  localparam int MW  = IW + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              io_wr,
  input  logic [3:0]        io_adr,
  input  logic [7:0]        io_din,
  input  logic [NCH*IW-1:0] ch_in,
  input  logic              smp_stb,
  output logic [MW-1:0]     mix_out,
  output logic              dac_out,
  output logic              busy,
  output logic              clip,
  output logic              ovr
);

  localparam int AW = IW + GW + 4;

  state_e          state_q, state_d;
  logic [3:0]      idx_q;
  logic [GW-1:0]   gain_q [NCH];
  logic [IW-1:0]   snap_q [NCH];
  logic [AW-1:0]   acc_q;
  logic            mute_q, clip_q, ovr_q;

  logic            ctrl_wr, clr_flags, start, last_ch, clip_set, ovr_set;
  logic [IW-1:0]   ch_sel;
  logic [GW-1:0]   gain_sel;
  logic [AW-1:0]   prod;
  logic [MW-1:0]   mix_sat;
  logic            sat_hit;

  // Scale the accumulator by the gain shift and clamp to full scale; MSB flags a clamp.
  function automatic logic [MW:0] sat_mix(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> GAIN_SHIFT;
    if (|s[AW-1:MW]) return {1'b1, {MW{1'b1}}};
    else             return {1'b0, s[MW-1:0]};
  endfunction

  assign ctrl_wr   = io_wr && (io_adr == 4'(ADR_CTRL));
  assign clr_flags = ctrl_wr && io_din[1];
  assign busy      = (state_q != ST_IDLE);
  assign start     = smp_stb && !busy;
  assign ovr_set   = smp_stb && busy;
  assign last_ch   = (idx_q == 4'(NCH - 1));
  assign {sat_hit, mix_sat} = sat_mix(acc_q);
  assign clip_set  = (state_q == ST_OUT) && sat_hit;
  assign prod      = AW'(ch_sel) * AW'(gain_sel);
  assign clip      = clip_q;
  assign ovr       = ovr_q;

  // Pick the channel sample and live gain for the current accumulate step.
  always_comb begin
    ch_sel   = '0;
    gain_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == 4'(k)) begin
        ch_sel   = snap_q[k];
        gain_sel = gain_q[k];
      end
    end
  end

  // Sequencer next state: IDLE -> ACC (NCH cycles) -> OUT -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (smp_stb) state_d = ST_ACC;
      ST_ACC:  if (last_ch) state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Control registers: channel index, gains, mute, sticky flags, output sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      mute_q  <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
      mix_out <= '0;
      for (int k = 0; k < NCH; k++) gain_q[k] <= GW'(GAIN_UNITY);
    end else begin
      if (start)                 idx_q <= '0;
      else if (state_q == ST_ACC) idx_q <= idx_q + 4'd1;
      for (int k = 0; k < NCH; k++)
        if (io_wr && (io_adr == 4'(k))) gain_q[k] <= io_din[GW-1:0];
      if (ctrl_wr) mute_q <= io_din[0];
      clip_q <= (clip_q && !clr_flags) || clip_set;
      ovr_q  <= (ovr_q  && !clr_flags) || ovr_set;
      if (state_q == ST_OUT) mix_out <= mute_q ? '0 : mix_sat;
    end
  end

  // Datapath: sample snapshot and multiply-accumulate.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int k = 0; k < NCH; k++) snap_q[k] <= ch_in[k*IW +: IW];
      acc_q <= '0;
    end else if (state_q == ST_ACC) begin
      acc_q <= acc_q + prod;
    end
  end

  dsm_mod #(.MW(MW)) u_dsm (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .din_i  (mix_out),
    .dout_o (dac_out)
  );

endmodule

// File: tb/tb_audio_mixer_dsm.sv
// Scoreboard bench for audio_mixer_dsm: stimulus pushes expected mix results,
// a negedge monitor pops and compares on every completed mix sequence.
module tb_audio_mixer_dsm;

  localparam int NCH = 6;
  localparam int IW  = 10;
  localparam int GW  = 4;
  localparam int MW  = IW + 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              io_wr = 1'b0;
  logic [3:0]        io_adr = '0;
  logic [7:0]        io_din = '0;
  logic [NCH*IW-1:0] ch_in = '0;
  logic              smp_stb = 1'b0;
  logic [MW-1:0]     mix_out;
  logic              dac_out, busy, clip, ovr;

  audio_mixer_dsm #(.NCH(NCH), .IW(IW), .GW(GW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_wr   (io_wr),
    .io_adr  (io_adr),
    .io_din  (io_din),
    .ch_in   (ch_in),
    .smp_stb (smp_stb),
    .mix_out (mix_out),
    .dac_out (dac_out),
    .busy    (busy),
    .clip    (clip),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mix;
    int clp;
    int stb_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk_eq(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endfunction

  function automatic void chk_rng(string name, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
    end
  endfunction

  // Monitor: a busy falling edge marks a mix_out update.
  int          busy_cnt = 0;
  logic        prev_busy = 1'b0;
  logic [MW-1:0] prev_mix = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
      prev_mix  = mix_out;
    end else begin
      if (prev_busy && !busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update mix_out=%0d expected=none", mix_out);
        end else begin
          e = exp_q.pop_front();
          chk_eq("mix_out", int'(mix_out), e.mix);
          chk_eq("clip_at_update", int'(clip), e.clp);
          chk_eq("update_latency", cyc - e.stb_cyc, NCH + 1);
          chk_eq("busy_cycles", busy_cnt, NCH + 1);
        end
        busy_cnt = 0;
      end else if (mix_out != prev_mix) begin
        checks++;
        failures++;
        $display("FAIL mix_out_hold actual=%0d expected=%0d", mix_out, prev_mix);
      end
      if (busy) busy_cnt++;
      prev_busy = busy;
      prev_mix  = mix_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int adr, input int din);
    io_wr  = 1'b1;
    io_adr = 4'(adr);
    io_din = 8'(din);
    tick();
    io_wr  = 1'b0;
  endtask

  task automatic set_ch(input int k, input int v);
    ch_in[k*IW +: IW] = IW'(v);
  endtask

  task automatic set_all(input int v0, input int v1, input int v2,
                         input int v3, input int v4, input int v5);
    set_ch(0, v0); set_ch(1, v1); set_ch(2, v2);
    set_ch(3, v3); set_ch(4, v4); set_ch(5, v5);
  endtask

  task automatic strobe(input int expmix, input int expclip);
    exp_t e;
    e.mix = expmix;
    e.clp = expclip;
    e.stb_cyc = cyc + 1;
    exp_q.push_back(e);
    smp_stb = 1'b1;
    tick();
    smp_stb = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_idle_timeout busy=%0d pending=%0d", busy, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    // Reset state
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk_eq("rst_mix_out", int'(mix_out), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_clip", int'(clip), 0);
    chk_eq("rst_ovr", int'(ovr), 0);
    chk_eq("rst_dac_out", int'(dac_out), 0);

    // Single channel at unity gain
    set_all(512, 0, 0, 0, 0, 0);
    strobe(512, 0);
    wait_idle();

    // Mixed gains: 100*8+200*4+300*0+400*15+500*8+600*8 = 16400 -> 2050
    wr(1, 4); wr(2, 0); wr(3, 15);
    set_all(100, 200, 300, 400, 500, 600);
    strobe(2050, 0);
    wait_idle();

    // Full scale with max gains saturates and sets clip; flag clear
    for (int k = 0; k < NCH; k++) wr(k, 15);
    set_all(1023, 1023, 1023, 1023, 1023, 1023);
    strobe(4095, 1);
    wait_idle();
    chk_eq("clip_set", int'(clip), 1);
    wr(15, 2);
    chk_eq("clip_cleared", int'(clip), 0);

    // Clear write landing on the OUT cycle that clips: clip stays set
    strobe(4095, 1);
    repeat (6) tick();
    wr(15, 2);
    wait_idle();
    chk_eq("clip_set_wins", int'(clip), 1);
    wr(15, 2);
    chk_eq("clip_cleared2", int'(clip), 0);
    for (int k = 0; k < NCH; k++) wr(k, 8);

    // Gain writes during accumulation: ch0 already summed, ch5 not yet
    set_all(10, 20, 30, 40, 50, 60);
    strobe(150, 0);
    wr(0, 0);
    wr(5, 0);
    wait_idle();
    wr(0, 8); wr(5, 8);

    // Strobe while busy: ignored, sets ovr, single update
    set_all(512, 0, 0, 0, 0, 0);
    strobe(512, 0);
    tick();
    smp_stb = 1'b1;
    tick();
    smp_stb = 1'b0;
    wait_idle();
    repeat (NCH + 3) tick();
    chk_eq("ovr_set", int'(ovr), 1);
    wr(15, 2);
    chk_eq("ovr_cleared", int'(ovr), 0);

    // Modulator density: 1024/4096 ones
    set_all(512, 512, 0, 0, 0, 0);
    strobe(1024, 0);
    wait_idle();
    ones = 0;
    repeat (4096) begin
      @(negedge clk);
      if (dac_out) ones++;
    end
    chk_rng("dsm_ones_1024", ones, 1023, 1025);

    // Reset during accumulation abandons the sequence and restores gains
    tick();
    wr(0, 3);
    set_all(512, 0, 0, 0, 0, 0);
    smp_stb = 1'b1;
    tick();
    smp_stb = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk_eq("rst_acc_mix_out", int'(mix_out), 0);
    chk_eq("rst_acc_busy", int'(busy), 0);
    repeat (NCH + 3) tick();
    chk_eq("rst_acc_no_update", int'(mix_out), 0);
    strobe(512, 0);
    wait_idle();

    // Mute forces zero output and a silent bitstream
    wr(15, 1);
    set_all(512, 512, 0, 0, 0, 0);
    strobe(0, 0);
    wait_idle();
    repeat (4) tick();
    ones = 0;
    repeat (200) begin
      @(negedge clk);
      if (dac_out) ones++;
    end
    chk_eq("mute_dac_ones", ones, 0);
    tick();
    wr(15, 0);

    chk_eq("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
